main_decoder_pipe: RTL and testbench

Registered, parametrised successor to the combinational main decoder. Decodes a full 32-bit RV32I instruction (opcode, funct3, funct7) into the ID/EX control bundle, holds it in one pipeline register with valid/ready handshake, flush, and an illegal-instruction halt FSM. Sits between fetch/IF-ID and the execute stage. Optionally decodes RV32M.

---
 rtl/main_decoder_pipe_pkg.sv | 73 +++++++
 rtl/main_decoder_comb.sv | 114 +++++++++++
 rtl/main_decoder_pipe.sv | 156 +++++++++++++++
 tb/tb_main_decoder_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_decoder_pipe_pkg.sv
// Shared decode types for main_decoder_pipe: opcodes, funct7 values,
// ImmSrc/ResultSrc/ALUOp/load encodings, ID/EX control bundle, FSM states.
package main_decoder_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNC   = 2'b10,
    ALU_MULDIV = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic     reg_write;
    logic     alu_src;
    logic     mem_write;
    logic     jump;
    logic     jalr;
    logic     branch;
    logic     row;
    logic     load_sign;
    logic     auipc;
    logic     muldiv;
    imm_src_e imm_src;
    res_src_e result_src;
    alu_op_e  alu_op;
    logic [1:0] load;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic logic load_f3_bad(input logic [2:0] f3);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/main_decoder_comb.sv
// Pure combinational RV32I(+M with RV32M_EN) main decode.
// Ports: instr in; ctrl bundle, illegal flag, rd/rs1/rs2 fields out.
module main_decoder_comb
  import main_decoder_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       m_ok;
  logic       r_ok;
  ctrl_t      c;
  logic       bad;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

`ifdef RV32M_EN
  assign m_ok = (f7 == F7_MULDIV);
`else
  assign m_ok = 1'b0;
`endif

  // SUB/SRA share funct7 0100000; only funct3 000/101 accept it
  assign r_ok = (f7 == F7_BASE)
              | ((f7 == F7_ALT) & ((f3 == 3'b000) | (f3 == 3'b101)));

  always_comb begin
    c   = '0;
    bad = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD): begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = RES_MEM;
        c.row        = 1'b1;
        c.load       = f3[1:0];
        c.load_sign  = ~f3[2];
        bad          = load_f3_bad(f3);
      end
      (op == OP_STORE): begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_src   = IMM_S;
        c.load      = f3[1:0];
        bad         = f3 > 3'b010;
      end
      (op == OP_R): begin
        c.reg_write = 1'b1;
        if (m_ok) begin
          c.alu_op = ALU_MULDIV;
          c.muldiv = 1'b1;
        end else begin
          c.alu_op = ALU_FUNC;
          bad      = ~r_ok;
        end
      end
      (op == OP_I): begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_FUNC;
      end
      (op == OP_BRANCH): begin
        c.branch  = 1'b1;
        c.alu_op  = ALU_BRANCH;
        c.imm_src = IMM_B;
        bad       = (f3[2:1] == 2'b01);
      end
      (op == OP_JAL): begin
        c.reg_write  = 1'b1;
        c.jump       = 1'b1;
        c.result_src = RES_PC4;
        c.imm_src    = IMM_J;
      end
      (op == OP_JALR): begin
        c.reg_write  = 1'b1;
        c.jalr       = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = RES_PC4;
        bad          = (f3 != 3'b000);
      end
      (op == OP_LUI): begin
        c.reg_write  = 1'b1;
        c.result_src = RES_IMM;
        c.imm_src    = IMM_U;
      end
      (op == OP_AUIPC): begin
        c.reg_write  = 1'b1;
        c.result_src = RES_IMM;
        c.imm_src    = IMM_U;
        c.auipc      = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    // an illegal bundle must never enable a write or redirect
    if (bad) c = '0;
  end

  assign ctrl    = c;
  assign illegal = bad;

endmodule

// File: rtl/main_decoder_pipe.sv
// Registered main decoder: decode + ID/EX register, valid/ready, flush,
// illegal-halt FSM, saturating illegal counter. RV32M_EN enables mul/div.
// Ports: clk, reset (async low), in_* from IF/ID, out_*/controls to EX,
// illegal, halted, ill_count.
module main_decoder_pipe
  import main_decoder_pipe_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int IMM_SRC_W = 3,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic                 Jump,
  output logic                 Jalr,
  output logic                 Branch,
  output logic                 row,
  output logic                 LoadSign,
  output logic                 Auipc,
  output logic                 MulDiv,
  output logic [IMM_SRC_W-1:0] ImmSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUOp,
  output logic [1:0]           load,
  output logic                 illegal,
  output logic                 halted,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_t      ctrl_d;
  logic       ill_d;
  logic [4:0] rd_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;

  ctrl_t                ctrl_q;
  logic                 ill_q;
  logic                 vld_q;
  logic [PC_W-1:0]      pc_q;
  logic [4:0]           rd_q;
  logic [4:0]           rs1_q;
  logic [4:0]           rs2_q;
  logic [ILL_CNT_W-1:0] cnt_q;
  state_e               state_q;
  state_e               state_d;

  logic take;

  main_decoder_comb u_comb (
    .instr   (in_instr),
    .ctrl    (ctrl_d),
    .illegal (ill_d),
    .rd      (rd_d),
    .rs1     (rs1_d),
    .rs2     (rs2_d)
  );

  assign in_ready = (state_q == ST_RUN) & (~vld_q | out_ready);
  // flush drops a same-cycle offer entirely
  assign take     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
      pc_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (flush) begin
        vld_q <= 1'b0;
      end else if (take) begin
        vld_q <= 1'b1;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
      if (take) begin
        ctrl_q <= ctrl_d;
        ill_q  <= ill_d;
        pc_q   <= in_pc;
        rd_q   <= rd_d;
        rs1_q  <= rs1_d;
        rs2_q  <= rs2_d;
      end
      if (take & ill_d & ~(&cnt_q)) begin
        cnt_q <= cnt_q + ILL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (take & ill_d) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ImmSrc      = '0;
    ImmSrc[2:0] = ctrl_q.imm_src;
  end

  assign out_valid = vld_q;
  assign out_pc    = pc_q;
  assign out_rd    = rd_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign RegWrite  = ctrl_q.reg_write;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign Jump      = ctrl_q.jump;
  assign Jalr      = ctrl_q.jalr;
  assign Branch    = ctrl_q.branch;
  assign row       = ctrl_q.row;
  assign LoadSign  = ctrl_q.load_sign;
  assign Auipc     = ctrl_q.auipc;
  assign MulDiv    = ctrl_q.muldiv;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUOp     = ctrl_q.alu_op;
  assign load      = ctrl_q.load;
  assign illegal   = ill_q;
  assign halted    = (state_q == ST_HALT);
  assign ill_count = cnt_q;

endmodule

// File: tb/tb_main_decoder_pipe.sv
// Scoreboard bench for main_decoder_pipe.
// Expected bundles queued on accept, compared when EX consumes.
module tb_main_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        RegWrite, ALUSrc, MemWrite, Jump, Jalr, Branch;
  logic        row, LoadSign, Auipc, MulDiv, illegal, halted;
  logic [2:0]  ImmSrc;
  logic [1:0]  ResultSrc, ALUOp, load;
  logic [7:0]  ill_count;

  always #5 clk = ~clk;

  main_decoder_pipe #(
    .PC_W(32), .IMM_SRC_W(3), .ILL_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .Jump(Jump), .Jalr(Jalr), .Branch(Branch), .row(row),
    .LoadSign(LoadSign), .Auipc(Auipc), .MulDiv(MulDiv),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .load(load), .illegal(illegal), .halted(halted),
    .ill_count(ill_count)
  );

  // rw as mw j jr br row ls au md _ imm _ res _ aluop _ load _ ill
  localparam logic [19:0] E_LW    = 20'b1100001100_000_01_00_10_0;
  localparam logic [19:0] E_LBU   = 20'b1100001000_000_01_00_00_0;
  localparam logic [19:0] E_SW    = 20'b0110000000_001_00_00_10_0;
  localparam logic [19:0] E_ADD   = 20'b1000000000_000_00_10_00_0;
  localparam logic [19:0] E_ADDI  = 20'b1100000000_000_00_10_00_0;
  localparam logic [19:0] E_BEQ   = 20'b0000010000_010_00_01_00_0;
  localparam logic [19:0] E_JAL   = 20'b1001000000_011_10_00_00_0;
  localparam logic [19:0] E_JALR  = 20'b1100100000_000_10_00_00_0;
  localparam logic [19:0] E_LUI   = 20'b1000000000_100_11_00_00_0;
  localparam logic [19:0] E_AUIPC = 20'b1000000010_100_11_00_00_0;
  localparam logic [19:0] E_MUL   = 20'b1000000001_000_00_11_00_0;
  localparam logic [19:0] E_ILL   = 20'b0000000000_000_00_00_00_1;

  typedef struct packed {
    logic [19:0] ctrl;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  exp_t        e;
  logic [31:0] pc = 32'h1000;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  exp_cnt = 8'd0;

  wire [19:0] obs = {RegWrite, ALUSrc, MemWrite, Jump, Jalr, Branch,
                     row, LoadSign, Auipc, MulDiv, ImmSrc, ResultSrc,
                     ALUOp, load, illegal};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("ctrl", obs, e.ctrl);
          check("pc", out_pc, e.pc);
          check("rd", out_rd, e.rd);
          check("rs1", out_rs1, e.rs1);
          check("rs2", out_rs2, e.rs2);
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back(cur);
    end
  end

  task automatic offer(input logic [31:0] ins, input logic [19:0] c);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    cur      = '{ctrl: c, pc: pc, rd: ins[11:7],
                 rs1: ins[19:15], rs2: ins[24:20]};
    pc       = pc + 32'd4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [19:0] c);
    offer(ins, c);
    @(negedge clk);
    check("in_ready_send", in_ready, 1);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  logic [31:0] bad_ins[3];

  initial begin
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    cur       = '0;
    #1 reset  = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", obs, 0);
    check("rst_halted", halted, 0);
    check("rst_ill_count", ill_count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_regs", {out_rd, out_rs1, out_rs2}, 0);
    step();
    reset     = 1'b1;
    out_ready = 1'b1;

    send(32'h00812283, E_LW);
    idle();

    send(32'h002081B3, E_ADD);
    send(32'h00208463, E_BEQ);
    send(32'h010000EF, E_JAL);
    send(32'h00512423, E_SW);
    send(32'h00508093, E_ADDI);
    send(32'h402081B3, E_ADD);
    send(32'h00814283, E_LBU);
    send(32'h000080E7, E_JALR);
    send(32'h123450B7, E_LUI);
    send(32'h00001097, E_AUIPC);
    idle();

    out_ready = 1'b0;
    send(32'h002081B3, E_ADD);
    offer(32'h00508093, E_ADDI);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_rd", out_rd, 3);
      check("stall_ctrl", obs, E_ADD);
      step();
    end
    out_ready = 1'b1;
    step();
    idle();
    idle();

    send(32'hFFFFFFFF, E_ILL);
    exp_cnt  = exp_cnt + 8'd1;
    in_valid = 1'b0;
    @(negedge clk);
    check("halt_halted", halted, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_count", ill_count, exp_cnt);
    step();
    offer(32'h00812283, E_LW);
    @(negedge clk);
    check("halt_drained", out_valid, 0);
    check("halt_blocked", in_ready, 0);
    step();
    do_flush();
    @(negedge clk);
    check("flush_halted", halted, 0);
    check("flush_count", ill_count, exp_cnt);
    check("flush_in_ready", in_ready, 1);
    step();

    offer(32'hFFFFFFFF, E_ILL);
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("fa_out_valid", out_valid, 0);
    check("fa_count", ill_count, exp_cnt);
    check("fa_halted", halted, 0);
    step();

    bad_ins[0] = 32'h00813283;
    bad_ins[1] = 32'h4020C1B3;
    bad_ins[2] = 32'h00812280;
    for (int i = 0; i < 3; i++) begin
      send(bad_ins[i], E_ILL);
      exp_cnt = exp_cnt + 8'd1;
      idle();
      check("bad_halted", halted, 1);
      check("bad_count", ill_count, exp_cnt);
      do_flush();
    end

`ifdef RV32M_EN
    send(32'h023100B3, E_MUL);
    idle();
    check("mul_halted", halted, 0);
`else
    send(32'h023100B3, E_ILL);
    exp_cnt = exp_cnt + 8'd1;
    idle();
    check("mul_halted", halted, 1);
    check("mul_count", ill_count, exp_cnt);
    do_flush();
`endif
    idle();

    out_ready = 1'b0;
    send(32'h00812283, E_LW);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", ill_count, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_ctrl", obs, 0);
    sb.delete();
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    send(32'h002081B3, E_ADD);
    idle();
    idle();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
